// File: rtl/preg_elastic.sv
// Elastic pipeline register: 2-entry skid buffer (main M + skid S) with
// valid/ready on both sides, control-only squash on flush/drain, and perf counters.
module preg_elastic #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Handshake: a beat transfers on a side in any cycle where valid and ready
  // are both high at the rising edge. in_ready depends only on the state
  // register, so there is no combinational path from out_ready to in_ready.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic              in_fire, out_fire, stall_hit, flush_hit;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;
  // The state encoding doubles as the entry count and as the FSM debug view.
  assign occupancy = state_q;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign stall_hit = out_valid & ~out_ready;
  assign flush_hit = flush & ((state_q != EMPTY) | in_valid);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= EMPTY;
      m_data_q <= '0;
      s_data_q <= '0;
      m_ctrl_q <= '0;
      s_ctrl_q <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_ctrl_q <= s_ctrl_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    m_ctrl_d = m_ctrl_q;
    s_ctrl_d = s_ctrl_q;
    if (flush) begin
      // Datapath fields are left alone; only control must never leak.
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d  = ONE;
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            state_d  = FULL;
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            // Draining to a bubble clears control so out_ctrl is 0 while invalid.
            state_d  = EMPTY;
            m_ctrl_d = '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d  = ONE;
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
          end
        end
        default: begin
          state_d  = EMPTY;
          m_ctrl_d = '0;
          s_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_hit && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_hit && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
